nts_ntp_header_rx: RTL and testbench
====================================

// Module: nts_ntp_header_rx
// PURPOSE
//  Receiving end of the NTP header block-write stream (wr_en / 3-bit block index / 64-bit data, six blocks 0..5).
//  Checks block ordering, buffers one 384-bit header and drains it as six 64-bit words over valid/ready
//  toward the TX packet buffer. Ordering violations, timeouts and overruns are counted.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max idle cycles between consecutive blocks while collecting (1..255)
//  ERR_CNT_WIDTH   16  width of saturating error counter
// PORTS
//  i_clk            in   1    clock
//  i_areset_n       in   1    asynchronous active-low reset
//  i_clear          in   1    abort current header, return to idle
//  i_wr_en          in   1    header block write strobe
//  i_block          in   3    block index 0..5
//  i_data           in   64   header block data (block 0 = LI|VN|Mode|Stratum|Poll|Precision|RootDelay)
//  o_busy           out  1    state != IDLE
//  o_hdr_valid      out  1    output word valid
//  i_hdr_ready      in   1    downstream accepts word
//  o_hdr_word       out  64   buffered block rd_idx
//  o_hdr_index      out  3    index of o_hdr_word
//  o_hdr_last       out  1    o_hdr_valid && index==5
//  o_overrun        out  1    1-cycle pulse: wr_en dropped while DRAIN
//  o_err_count      out  ERR_CNT_WIDTH  saturating count of ordering/timeout/overrun errors
// BEHAVIOUR
//  Reset (i_areset_n=0, async): state=IDLE, cnt=0, rd_idx=0, timer=0, buffer=0, all outputs 0.
//  States: IDLE, COLLECT, DRAIN. All registered; outputs derived from registers only.
//  IDLE: wr_en&&block==0 -> store buf[0], cnt=1, timer=0, ->COLLECT. wr_en&&block!=0 -> err++, stay.
//  COLLECT: wr_en&&block==cnt -> store buf[cnt], timer=0; cnt==5 -> rd_idx=0, ->DRAIN else cnt++.
//   wr_en&&block!=cnt: err++; block==0 -> restart (store buf[0], cnt=1, stay) else ->IDLE.
//   no wr_en: timer++; timer==TIMEOUT_CYCLES-1 -> err++, ->IDLE (partial header discarded).
//  DRAIN: o_hdr_valid=1, o_hdr_word=buf[rd_idx], o_hdr_index=rd_idx. valid&&ready -> rd_idx++;
//   transfer with rd_idx==5 -> ->IDLE, rd_idx=0. o_hdr_word/index stable while valid&&!ready.
//   wr_en in DRAIN: dropped, o_overrun pulses next cycle, err++, drain continues unaffected.
//  Latency: block 5 accepted cycle N -> o_hdr_valid=1 in N+1; min 6 cycles to drain with ready=1.
//  Buffer writes only through accepted blocks; buffer not cleared on i_clear (contents don't-care).
//  i_clear: synchronous, any state -> IDLE, cnt/rd_idx/timer=0, next cycle; beats simultaneous wr_en
//   (dropped, not counted) and in-flight handshake (word not transferred). o_err_count NOT cleared.
//  o_err_count saturates at all-ones; multiple error causes in one cycle count once.
//  block>5 treated as ordering error. Back-to-back header: block 0 arriving in the cycle DRAIN
//   completes is an overrun (state still DRAIN); next header must start from IDLE.
// CONFIGURATION
//  NTS_NTP_HEADER_RX_FIELDS_EN defined: extra outputs o_fields_valid(1), o_vn(3), o_mode(3),
//   o_stratum(8), o_tx_ts(64), latched from buf[0][61:59], [58:56], [55:48], buf[5] on block 5
//   acceptance; o_fields_valid set same cycle DRAIN entered, cleared by i_clear/reset only.
//  Not defined: those ports and registers absent; all other behaviour identical.
// TESTING
//  T1 blocks 0..5 consecutive, data 64'h1111..(k) per block, ready=1 -> six words index 0..5 in order,
//   o_hdr_last on index 5, o_busy low 7 cycles after block 5, err=0.
//  T2 blocks 0,1,3 -> err=1, state IDLE; then full 0..5 header drains correctly.
//  T3 blocks 0,1 then 16 idle cycles (TIMEOUT_CYCLES=16) -> err=1, o_busy=0; no o_hdr_valid.
//  T4 full header, ready=0 for 10 cycles then 1 -> word 0 held stable, all six transferred once;
//   wr_en block 0 during hold -> o_overrun pulse, err=1, drain data unchanged.
//  T5 i_clear mid-COLLECT (after block 2) and mid-DRAIN (after 3 words) -> IDLE next cycle,
//   err unchanged; subsequent header correct. Reset mid-DRAIN -> all outputs 0 immediately.
//  T6 force 65536 ordering errors (ERR_CNT_WIDTH=16) -> o_err_count holds 16'hFFFF.
//  With FIELDS_EN: block0=64'h2300_0000_..., block5=64'hDEAD_BEEF_0123_4567 -> vn=4, mode=3, tx_ts match.

Source files
------------

// File: rtl/nts_ntp_header_rx_if.sv
// Bus bundle for the NTP header receiver: the block-write stream coming in
// and the buffered header words drained out over valid/ready.
// slave  = receiver side (nts_ntp_header_rx)
// master = producer / downstream side (block writer and TX packet buffer)
interface nts_ntp_header_rx_if;
    logic        i_wr_en;
    logic [2:0]  i_block;
    logic [63:0] i_data;
    logic        o_hdr_valid;
    logic        i_hdr_ready;
    logic [63:0] o_hdr_word;
    logic [2:0]  o_hdr_index;
    logic        o_hdr_last;

    modport slave (
        input  i_wr_en,
        input  i_block,
        input  i_data,
        input  i_hdr_ready,
        output o_hdr_valid,
        output o_hdr_word,
        output o_hdr_index,
        output o_hdr_last
    );

    modport master (
        output i_wr_en,
        output i_block,
        output i_data,
        output i_hdr_ready,
        input  o_hdr_valid,
        input  o_hdr_word,
        input  o_hdr_index,
        input  o_hdr_last
    );
endinterface

// File: rtl/nts_ntp_header_rx.sv
// NTP header receiver: collects the six 64-bit header blocks in strict
// order 0..5, buffers the 384-bit header and drains it as six words over
// valid/ready. Ordering errors, collection timeouts and writes that arrive
// while draining are counted in a saturating error counter.
// Optional build macro NTS_NTP_HEADER_RX_FIELDS_EN adds decoded header
// fields (VN, Mode, Stratum, transmit timestamp) latched on header completion.
module nts_ntp_header_rx #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ERR_CNT_WIDTH  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_areset_n,
    input  logic                     i_clear,
    nts_ntp_header_rx_if.slave       bus,
    output logic                     o_busy,
    output logic                     o_overrun,
    output logic [ERR_CNT_WIDTH-1:0] o_err_count
`ifdef NTS_NTP_HEADER_RX_FIELDS_EN
    ,
    output logic                     o_fields_valid,
    output logic [2:0]               o_vn,
    output logic [2:0]               o_mode,
    output logic [7:0]               o_stratum,
    output logic [63:0]              o_tx_ts
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam logic [2:0] LAST_BLOCK = 3'd5;
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                   state;
    state_t                   state_next;
    logic [2:0]               cnt;
    logic [2:0]               cnt_next;
    logic [2:0]               rd_idx;
    logic [2:0]               rd_idx_next;
    logic [7:0]               timer;
    logic [7:0]               timer_next;
    logic [63:0]              hdr_buf [6];
    logic                     buf_we;
    logic [2:0]               buf_waddr;
    logic                     err_event;
    logic                     overrun_next;
    logic                     overrun;
    logic [ERR_CNT_WIDTH-1:0] err_count;
    logic [63:0]              word_mux;
    logic                     draining;

    // State, block counter, read pointer and idle timer registers
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            rd_idx <= 3'd0;
            timer  <= 8'd0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            rd_idx <= rd_idx_next;
            timer  <= timer_next;
        end
    end

    // Next-state logic: block ordering, timeout, drain handshake and clear
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        rd_idx_next  = rd_idx;
        timer_next   = timer;
        buf_we       = 1'b0;
        buf_waddr    = bus.i_block;
        err_event    = 1'b0;
        overrun_next = 1'b0;

        if (i_clear) begin
            state_next  = IDLE;
            cnt_next    = 3'd0;
            rd_idx_next = 3'd0;
            timer_next  = 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_wr_en) begin
                        if (bus.i_block == 3'd0) begin
                            buf_we     = 1'b1;
                            cnt_next   = 3'd1;
                            timer_next = 8'd0;
                            state_next = COLLECT;
                        end else begin
                            err_event = 1'b1;
                        end
                    end
                end

                COLLECT: begin
                    if (bus.i_wr_en) begin
                        if (bus.i_block == cnt) begin
                            buf_we     = 1'b1;
                            timer_next = 8'd0;
                            if (cnt == LAST_BLOCK) begin
                                rd_idx_next = 3'd0;
                                cnt_next    = 3'd0;
                                state_next  = DRAIN;
                            end else begin
                                cnt_next = cnt + 3'd1;
                            end
                        end else begin
                            err_event = 1'b1;
                            if (bus.i_block == 3'd0) begin
                                buf_we     = 1'b1;
                                cnt_next   = 3'd1;
                                timer_next = 8'd0;
                            end else begin
                                cnt_next   = 3'd0;
                                timer_next = 8'd0;
                                state_next = IDLE;
                            end
                        end
                    end else if (timer == TIMER_LAST) begin
                        err_event  = 1'b1;
                        cnt_next   = 3'd0;
                        timer_next = 8'd0;
                        state_next = IDLE;
                    end else begin
                        timer_next = timer + 8'd1;
                    end
                end

                DRAIN: begin
                    if (bus.i_wr_en) begin
                        err_event    = 1'b1;
                        overrun_next = 1'b1;
                    end
                    if (bus.i_hdr_ready) begin
                        if (rd_idx == LAST_BLOCK) begin
                            rd_idx_next = 3'd0;
                            state_next  = IDLE;
                        end else begin
                            rd_idx_next = rd_idx + 3'd1;
                        end
                    end
                end

                default: begin
                    state_next  = IDLE;
                    cnt_next    = 3'd0;
                    rd_idx_next = 3'd0;
                    timer_next  = 8'd0;
                end
            endcase
        end
    end

    // Header buffer: written only by accepted blocks, zeroed only by reset
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            for (int k = 0; k < 6; k++) begin
                hdr_buf[k] <= 64'd0;
            end
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (buf_we && (buf_waddr == 3'(k))) begin
                    hdr_buf[k] <= bus.i_data;
                end
            end
        end
    end

    // Overrun pulse and saturating error counter (one count per cycle max)
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            overrun   <= 1'b0;
            err_count <= '0;
        end else begin
            overrun <= overrun_next;
            if (err_event && (err_count != {ERR_CNT_WIDTH{1'b1}})) begin
                err_count <= err_count + ERR_CNT_WIDTH'(1);
            end
        end
    end

    // Select the buffered word at the read pointer for the drain port
    always_comb begin
        word_mux = 64'd0;
        for (int k = 0; k < 6; k++) begin
            if (rd_idx == 3'(k)) begin
                word_mux = hdr_buf[k];
            end
        end
    end

    assign draining        = (state == DRAIN);
    assign o_busy          = (state != IDLE);
    assign o_overrun       = overrun;
    assign o_err_count     = err_count;
    assign bus.o_hdr_valid = draining;
    assign bus.o_hdr_word  = draining ? word_mux : 64'd0;
    assign bus.o_hdr_index = draining ? rd_idx : 3'd0;
    assign bus.o_hdr_last  = draining && (rd_idx == LAST_BLOCK);

`ifdef NTS_NTP_HEADER_RX_FIELDS_EN
    logic enter_drain;

    assign enter_drain = !i_clear && (state == COLLECT) && bus.i_wr_en &&
                         (bus.i_block == cnt) && (cnt == LAST_BLOCK);

    // Decoded header fields, captured as the last block completes the header
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            o_fields_valid <= 1'b0;
            o_vn           <= 3'd0;
            o_mode         <= 3'd0;
            o_stratum      <= 8'd0;
            o_tx_ts        <= 64'd0;
        end else if (i_clear) begin
            o_fields_valid <= 1'b0;
        end else if (enter_drain) begin
            o_fields_valid <= 1'b1;
            o_vn           <= hdr_buf[0][61:59];
            o_mode         <= hdr_buf[0][58:56];
            o_stratum      <= hdr_buf[0][55:48];
            o_tx_ts        <= bus.i_data;
        end
    end
`endif

endmodule

// File: tb/tb_nts_ntp_header_rx.sv
// Self-checking bench for nts_ntp_header_rx: directed scenarios plus a
// randomized phase, all checked against a header-level reference model and
// a scoreboard of expected drained words.
`timescale 1ns/1ps
module tb_nts_ntp_header_rx;

    localparam int TIMEOUT    = 16;
    localparam int ERRW       = 16;
    localparam int SMALL_ERRW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear = 1'b0;
    logic            clear2 = 1'b0;
    logic            busy, overrun;
    logic [ERRW-1:0] err_count;
    logic            busy2, overrun2;
    logic [SMALL_ERRW-1:0] err_count2;

    int checks   = 0;
    int failures = 0;

    nts_ntp_header_rx_if bus();
    nts_ntp_header_rx_if bus2();

`ifdef NTS_NTP_HEADER_RX_FIELDS_EN
    logic        f_valid;
    logic [2:0]  f_vn, f_mode;
    logic [7:0]  f_stratum;
    logic [63:0] f_ts;
    logic        f2_valid;
    logic [2:0]  f2_vn, f2_mode;
    logic [7:0]  f2_stratum;
    logic [63:0] f2_ts;
`endif

    nts_ntp_header_rx #(.TIMEOUT_CYCLES(TIMEOUT), .ERR_CNT_WIDTH(ERRW)) dut (
        .i_clk(clk), .i_areset_n(rst_n), .i_clear(clear), .bus(bus),
        .o_busy(busy), .o_overrun(overrun), .o_err_count(err_count)
`ifdef NTS_NTP_HEADER_RX_FIELDS_EN
        , .o_fields_valid(f_valid), .o_vn(f_vn), .o_mode(f_mode),
        .o_stratum(f_stratum), .o_tx_ts(f_ts)
`endif
    );

    nts_ntp_header_rx #(.TIMEOUT_CYCLES(3), .ERR_CNT_WIDTH(SMALL_ERRW)) dut_small (
        .i_clk(clk), .i_areset_n(rst_n), .i_clear(clear2), .bus(bus2),
        .o_busy(busy2), .o_overrun(overrun2), .o_err_count(err_count2)
`ifdef NTS_NTP_HEADER_RX_FIELDS_EN
        , .o_fields_valid(f2_valid), .o_vn(f2_vn), .o_mode(f2_mode),
        .o_stratum(f2_stratum), .o_tx_ts(f2_ts)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state: blocks gathered so far, draining flag, errors
    typedef struct {
        logic [2:0]  idx;
        logic [63:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] parts [6];
    int          hdr_pos  = 0;
    int          idle_cnt = 0;
    bit          draining = 1'b0;
    int          exp_err  = 0;
    bit          random_ready = 1'b0;

`ifdef NTS_NTP_HEADER_RX_FIELDS_EN
    bit          exp_fv = 1'b0;
    logic [2:0]  exp_vn = 3'd0, exp_mode = 3'd0;
    logic [7:0]  exp_stratum = 8'd0;
    logic [63:0] exp_ts = 64'd0;
`endif

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void bump_err();
        if (exp_err < (1 << ERRW) - 1) exp_err++;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        hdr_pos  = 0;
        idle_cnt = 0;
        draining = 1'b0;
        exp_err  = 0;
`ifdef NTS_NTP_HEADER_RX_FIELDS_EN
        exp_fv = 1'b0; exp_vn = 3'd0; exp_mode = 3'd0; exp_stratum = 8'd0; exp_ts = 64'd0;
`endif
    endfunction

    // One cycle of header-level behaviour: what a write (or no write) means
    function automatic void model_cycle(input bit wr, input logic [2:0] blk,
                                        input logic [63:0] data, input bit clr,
                                        output bit ovr);
        ovr = 1'b0;
        if (clr) begin
            hdr_pos  = 0;
            idle_cnt = 0;
            draining = 1'b0;
            exp_q.delete();
`ifdef NTS_NTP_HEADER_RX_FIELDS_EN
            exp_fv = 1'b0;
`endif
            return;
        end
        if (draining) begin
            if (wr) begin
                ovr = 1'b1;
                bump_err();
            end
            return;
        end
        if (!wr) begin
            if (hdr_pos != 0) begin
                idle_cnt++;
                if (idle_cnt == TIMEOUT) begin
                    bump_err();
                    hdr_pos  = 0;
                    idle_cnt = 0;
                end
            end
            return;
        end
        idle_cnt = 0;
        if (int'(blk) == hdr_pos) begin
            parts[hdr_pos] = data;
            hdr_pos++;
            if (hdr_pos == 6) begin
                for (int k = 0; k < 6; k++) exp_q.push_back('{idx: 3'(k), word: parts[k]});
                draining = 1'b1;
                hdr_pos  = 0;
`ifdef NTS_NTP_HEADER_RX_FIELDS_EN
                exp_fv = 1'b1;
                exp_vn = parts[0][61:59];
                exp_mode = parts[0][58:56];
                exp_stratum = parts[0][55:48];
                exp_ts = parts[5];
`endif
            end
        end else begin
            bump_err();
            if (blk == 3'd0) begin
                parts[0] = data;
                hdr_pos  = 1;
            end else begin
                hdr_pos = 0;
            end
        end
    endfunction

    // Drive one cycle of inputs, advance the model, check cycle-level outputs
    task automatic applyStimulus(input bit wr, input logic [2:0] blk,
                                 input logic [63:0] data, input bit clr);
        bit ovr_exp;
        bus.i_wr_en = wr;
        bus.i_block = blk;
        bus.i_data  = data;
        clear       = clr;
        if (random_ready) bus.i_hdr_ready = ($urandom_range(0, 3) != 0);
        model_cycle(wr, blk, data, clr, ovr_exp);
        @(posedge clk);
        #1;
        bus.i_wr_en = 1'b0;
        clear       = 1'b0;
        checkOutput("overrun", 64'(overrun), 64'(ovr_exp));
        checkOutput("err_count", 64'(err_count), 64'(exp_err));
        checkOutput("busy", 64'(busy), 64'((hdr_pos != 0) || draining));
        checkOutput("hdr_valid", 64'(bus.o_hdr_valid), 64'(draining));
`ifdef NTS_NTP_HEADER_RX_FIELDS_EN
        checkOutput("fields_valid", 64'(f_valid), 64'(exp_fv));
        if (exp_fv) begin
            checkOutput("vn", 64'(f_vn), 64'(exp_vn));
            checkOutput("mode", 64'(f_mode), 64'(exp_mode));
            checkOutput("stratum", 64'(f_stratum), 64'(exp_stratum));
            checkOutput("tx_ts", f_ts, exp_ts);
        end
`endif
    endtask

    task automatic send_header();
        for (int k = 0; k < 6; k++) applyStimulus(1'b1, 3'(k), {$urandom, $urandom}, 1'b0);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            applyStimulus(1'b0, 3'd0, 64'd0, 1'b0);
            n++;
        end
        checkOutput("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard monitor: compare the presented word, pop on handshake
    always @(negedge clk) begin
        if (rst_n && !clear && bus.o_hdr_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("word_expected", 64'(exp_q.size() > 0), 64'd1);
            end else begin
                checkOutput("hdr_index", 64'(bus.o_hdr_index), 64'(exp_q[0].idx));
                checkOutput("hdr_word", bus.o_hdr_word, exp_q[0].word);
                checkOutput("hdr_last", 64'(bus.o_hdr_last), 64'(exp_q[0].idx == 3'd5));
                if (bus.i_hdr_ready) begin
                    if (exp_q[0].idx == 3'd5) draining = 1'b0;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        failures++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.i_wr_en = 1'b0; bus.i_block = 3'd0; bus.i_data = 64'd0; bus.i_hdr_ready = 1'b1;
        bus2.i_wr_en = 1'b0; bus2.i_block = 3'd0; bus2.i_data = 64'd0; bus2.i_hdr_ready = 1'b1;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_valid", 64'(bus.o_hdr_valid), 64'd0);
        checkOutput("rst_word", bus.o_hdr_word, 64'd0);
        checkOutput("rst_index", 64'(bus.o_hdr_index), 64'd0);
        checkOutput("rst_last", 64'(bus.o_hdr_last), 64'd0);
        checkOutput("rst_overrun", 64'(overrun), 64'd0);
        checkOutput("rst_err", 64'(err_count), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] T1 in-order header");
        for (int k = 0; k < 6; k++)
            applyStimulus(1'b1, 3'(k), 64'h1111_1111_1111_1111 * 64'(k + 1), 1'b0);
        wait_drain(20);
        applyStimulus(1'b0, 3'd0, 64'd0, 1'b0);
        checkOutput("t1_err", 64'(err_count), 64'd0);

        $display("[TB] T2 ordering error then good header");
        applyStimulus(1'b1, 3'd0, 64'hA0, 1'b0);
        applyStimulus(1'b1, 3'd1, 64'hA1, 1'b0);
        applyStimulus(1'b1, 3'd3, 64'hA3, 1'b0);
        checkOutput("t2_err", 64'(err_count), 64'd1);
        checkOutput("t2_idle", 64'(busy), 64'd0);
        send_header();
        wait_drain(20);

        $display("[TB] T3 collection timeout");
        applyStimulus(1'b1, 3'd0, 64'hB0, 1'b0);
        applyStimulus(1'b1, 3'd1, 64'hB1, 1'b0);
        repeat (TIMEOUT) applyStimulus(1'b0, 3'd0, 64'd0, 1'b0);
        checkOutput("t3_err", 64'(err_count), 64'd2);
        checkOutput("t3_busy", 64'(busy), 64'd0);

        $display("[TB] T4 backpressure with overrun");
        bus.i_hdr_ready = 1'b0;
        send_header();
        for (int i = 0; i < 10; i++)
            applyStimulus(i == 4, 3'd0, 64'hC0, 1'b0);
        checkOutput("t4_err", 64'(err_count), 64'd3);
        bus.i_hdr_ready = 1'b1;
        wait_drain(20);

        $display("[TB] T5 clear mid-collect and mid-drain");
        applyStimulus(1'b1, 3'd0, 64'hD0, 1'b0);
        applyStimulus(1'b1, 3'd1, 64'hD1, 1'b0);
        applyStimulus(1'b1, 3'd2, 64'hD2, 1'b0);
        applyStimulus(1'b1, 3'd3, 64'hD3, 1'b1);
        checkOutput("t5_clear_collect", 64'(busy), 64'd0);
        send_header();
        repeat (3) applyStimulus(1'b0, 3'd0, 64'd0, 1'b0);
        applyStimulus(1'b0, 3'd0, 64'd0, 1'b1);
        checkOutput("t5_clear_drain", 64'(bus.o_hdr_valid), 64'd0);
        checkOutput("t5_err", 64'(err_count), 64'd3);
        send_header();
        wait_drain(20);

        $display("[TB] T5 reset mid-drain");
        send_header();
        repeat (2) applyStimulus(1'b0, 3'd0, 64'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 64'(bus.o_hdr_valid), 64'd0);
        checkOutput("arst_word", bus.o_hdr_word, 64'd0);
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_err", 64'(err_count), 64'd0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef NTS_NTP_HEADER_RX_FIELDS_EN
        $display("[TB] header field decode");
        applyStimulus(1'b1, 3'd0, 64'h2300_0000_0000_0000, 1'b0);
        for (int k = 1; k < 5; k++) applyStimulus(1'b1, 3'(k), 64'(k), 1'b0);
        applyStimulus(1'b1, 3'd5, 64'hDEAD_BEEF_0123_4567, 1'b0);
        checkOutput("fld_vn", 64'(f_vn), 64'd4);
        checkOutput("fld_mode", 64'(f_mode), 64'd3);
        checkOutput("fld_ts", f_ts, 64'hDEAD_BEEF_0123_4567);
        wait_drain(20);
`endif

        $display("[TB] randomized traffic");
        random_ready = 1'b1;
        for (int it = 0; it < 400; it++) begin
            int r;
            int gap;
            r = $urandom_range(0, 99);
            if (r < 60) begin
                applyStimulus(1'b1, 3'(draining ? 0 : hdr_pos), {$urandom, $urandom}, 1'b0);
            end else if (r < 75) begin
                applyStimulus(1'b1, 3'($urandom_range(0, 7)), {$urandom, $urandom}, 1'b0);
            end else if (r < 90) begin
                gap = $urandom_range(1, 20);
                repeat (gap) applyStimulus(1'b0, 3'd0, 64'd0, 1'b0);
            end else if (r < 93) begin
                applyStimulus($urandom_range(0, 1) == 1, 3'd0, 64'd0, 1'b1);
            end else begin
                applyStimulus(1'b0, 3'd0, 64'd0, 1'b0);
            end
        end
        random_ready = 1'b0;
        bus.i_hdr_ready = 1'b1;
        wait_drain(40);
        repeat (TIMEOUT + 2) applyStimulus(1'b0, 3'd0, 64'd0, 1'b0);

        $display("[TB] T6 error counter saturation");
        for (int i = 0; i < 20; i++) begin
            bus2.i_wr_en = 1'b1;
            bus2.i_block = 3'd1;
            bus2.i_data  = 64'(i);
            @(posedge clk);
            #1;
            checkOutput("sat_err", 64'(err_count2), 64'((i + 1 > 15) ? 15 : i + 1));
        end
        bus2.i_wr_en = 1'b0;
        checkOutput("sat_busy", 64'(busy2), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
